// File: rtl/kernel_bc_pkg.sv
// Shared types and constants for the BC kernel memory-side blocks.
package kernel_bc_pkg;

  typedef enum logic [2:0] {StIdle, StFill, StAddr, StData, StResp} state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned BYTES_PER_BEAT     = DEFAULT_DATA_WIDTH / 8;
  localparam int unsigned BOUNDARY_4K        = 4096;

endpackage

// File: rtl/kernel_bc_fifo_burst_writer_if.sv
// Upstream ap_fifo read port plus AXI4-style write channels of the burst writer.
interface kernel_bc_fifo_burst_writer_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  if_empty_n;
  logic                  if_read;
  logic                  if_read_ce;
  logic [DATA_WIDTH-1:0] if_dout;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  modport master (
    input  if_empty_n, if_dout, aw_ready, w_ready, b_valid, b_resp,
    output if_read, if_read_ce, aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready
  );

  modport slave (
    output if_empty_n, if_dout, aw_ready, w_ready, b_valid, b_resp,
    input  if_read, if_read_ce, aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready
  );

endinterface

// File: rtl/kernel_bc_burst_buf.sv
// Burst staging buffer: synchronous write, asynchronous indexed read.
module kernel_bc_burst_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kernel_bc_fifo_burst_writer.sv
// Drains an ap_fifo into memory as single-outstanding AXI write bursts.
// Define KERNEL_BC_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module kernel_bc_fifo_burst_writer
  import kernel_bc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  kernel_bc_fifo_burst_writer_if.master bus
);

  localparam int unsigned IW    = $clog2(MAX_BURST);
  localparam int unsigned BW    = IW + 1;
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [BW-1:0]         beats_q, fill_idx_q, rd_idx_q;
  logic                  busy_q, done_q, error_q;
  logic                  if_read_q, aw_valid_q, w_valid_q, b_ready_q;

  logic                  pop, last_beat;
  logic [BW-1:0]         fill_next, burst_limit, plan_beats;
  logic [CNT_WIDTH-1:0]  rem_after, plan_rem;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  assign pop       = if_read_q & bus.if_empty_n;
  assign fill_next = fill_idx_q + BW'(pop);
  assign last_beat = (rd_idx_q == beats_q - BW'(1));
  assign rem_after = remaining_q - CNT_WIDTH'(beats_q);
  assign next_addr = cur_addr_q + ADDR_WIDTH'(beats_q) * ADDR_WIDTH'(BYTES);

  // Size of the next burst, planned from the values the job/burst is about to load.
  assign plan_rem = (state_q == StIdle) ? word_count : rem_after;
`ifdef KERNEL_BC_4K_SPLIT_EN
  logic [11:0] plan_off;
  logic [12:0] room;
  assign plan_off    = (state_q == StIdle) ? base_addr[11:0] : next_addr[11:0];
  assign room        = (13'(BOUNDARY_4K) - {1'b0, plan_off}) / 13'(BYTES);
  assign burst_limit = (room < 13'(MAX_BURST)) ? BW'(room) : BW'(MAX_BURST);
`else
  assign burst_limit = BW'(MAX_BURST);
`endif
  assign plan_beats = (plan_rem < CNT_WIDTH'(burst_limit)) ? BW'(plan_rem) : burst_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      fill_idx_q  <= '0;
      rd_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      if_read_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_addr_q  <= base_addr;
            remaining_q <= word_count;
            error_q     <= 1'b0;
            beats_q     <= plan_beats;
            fill_idx_q  <= '0;
            if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StFill;
            end
          end
        end
        StFill: begin
          fill_idx_q <= fill_next;
          if_read_q  <= (fill_next < beats_q);
          if (fill_next == beats_q) begin
            aw_valid_q <= 1'b1;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          if (bus.aw_ready) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            rd_idx_q   <= '0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (bus.w_ready) begin
            if (last_beat) begin
              w_valid_q <= 1'b0;
              b_ready_q <= 1'b1;
              state_q   <= StResp;
            end else begin
              rd_idx_q <= rd_idx_q + BW'(1);
            end
          end
        end
        StResp: begin
          if (bus.b_valid) begin
            b_ready_q   <= 1'b0;
            error_q     <= error_q | (bus.b_resp != RESP_OKAY);
            cur_addr_q  <= next_addr;
            remaining_q <= rem_after;
            if (rem_after == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              // Pops resume immediately so back-to-back bursts carry no extra bubble.
              beats_q    <= plan_beats;
              fill_idx_q <= '0;
              if_read_q  <= 1'b1;
              state_q    <= StFill;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  kernel_bc_burst_buf #(
    .DEPTH (MAX_BURST),
    .WIDTH (DATA_WIDTH)
  ) u_burst_buf (
    .clk   (clk),
    .we    (pop),
    .waddr (fill_idx_q[IW-1:0]),
    .wdata (bus.if_dout),
    .raddr (rd_idx_q[IW-1:0]),
    .rdata (rd_data)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign bus.if_read    = if_read_q;
  assign bus.if_read_ce = 1'b1;
  assign bus.aw_valid   = aw_valid_q;
  assign bus.aw_addr    = cur_addr_q;
  assign bus.aw_len     = 8'(beats_q - BW'(1));
  assign bus.w_valid    = w_valid_q;
  assign bus.w_data     = rd_data;
  assign bus.w_last     = w_valid_q & last_beat;
  assign bus.b_ready    = b_ready_q;

endmodule

// File: tb/tb_kernel_bc_fifo_burst_writer.sv
// Bench for kernel_bc_fifo_burst_writer: queue-based job model plus literal burst pins.
module tb_kernel_bc_fifo_burst_writer;
  import kernel_bc_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned MB = 16;
  localparam int unsigned CW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, error;

  always #5 clk = ~clk;

  kernel_bc_fifo_burst_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  kernel_bc_fifo_burst_writer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] fifo_q[$];
  logic [63:0] exp_data[$];
  burst_t      exp_burst[$];
  burst_t      aw_log[$];
  logic [63:0] w_log[$];
  logic [1:0]  resp_plan[$];
  int          resp_idx = 0;
  logic        exp_error = 1'b0;
  int          beats_left = 0;
  int          done_cnt = 0, pop_cnt = 0, aw_cnt = 0;
  bit          wr_rand = 0, empty_toggle = 0, tog = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Job model: burst list from plain min() arithmetic, data from the words handed to the FIFO.
  task automatic plan_job(input logic [31:0] addr, input int unsigned count,
                          input logic [63:0] first);
    logic [31:0] a = addr;
    int unsigned rem = count, b, room;
    burst_t      bt;
    for (int i = 0; i < int'(count); i++) begin
      fifo_q.push_back(first + 64'(i));
      exp_data.push_back(first + 64'(i));
    end
    while (rem > 0) begin
      b = (rem < MB) ? rem : MB;
`ifdef KERNEL_BC_4K_SPLIT_EN
      room = (4096 - int'(a[11:0])) / BYTES_PER_BEAT;
      if (room < b) b = room;
`else
      room = 0;
`endif
      bt.addr = a;
      bt.len  = 8'(b - 1);
      exp_burst.push_back(bt);
      a   = a + 32'(b * BYTES_PER_BEAT);
      rem = rem - b;
    end
    exp_error = 1'b0;
    foreach (resp_plan[i]) exp_error |= (resp_plan[i] != RESP_OKAY);
    resp_idx = 0;
    aw_log.delete();
    w_log.delete();
    pop_cnt = 0;
    aw_cnt  = 0;
  endtask

  task automatic kick(input logic [31:0] addr, input int unsigned count);
    @(negedge clk);
    base_addr  = addr;
    word_count = count;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("done_within_budget", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_aw(input int i, input logic [31:0] addr, input logic [7:0] len);
    burst_t want;
    want.addr = addr;
    want.len  = len;
    if (i < aw_log.size()) check($sformatf("aw_log[%0d]", i), 64'(aw_log[i]), 64'(want));
    else check("aw_log_missing", 64'(aw_log.size()), 64'(i + 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_if_read"}, 64'(bus.if_read), 64'd0);
    check({tag, "_aw_valid"}, 64'(bus.aw_valid), 64'd0);
    check({tag, "_w_valid"}, 64'(bus.w_valid), 64'd0);
    check({tag, "_b_ready"}, 64'(bus.b_ready), 64'd0);
  endtask

  // Environment + compare process: drive slave inputs, then judge the handshakes of the next edge.
  always begin
    @(negedge clk);
    #1;
    tog = ~tog;
    bus.if_empty_n = (fifo_q.size() > 0) && !(empty_toggle && tog);
    bus.if_dout    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    bus.aw_ready   = 1'b1;
    bus.w_ready    = wr_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    bus.b_valid    = 1'b1;
    bus.b_resp     = (resp_idx < resp_plan.size()) ? resp_plan[resp_idx] : RESP_OKAY;
    if (!reset) begin
      if (bus.if_read && bus.if_empty_n) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
      if (bus.aw_valid && bus.aw_ready) begin
        burst_t got, want;
        got.addr = bus.aw_addr;
        got.len  = bus.aw_len;
        check("aw_one_outstanding", 64'(beats_left), 64'd0);
        check("aw_expected", 64'(exp_burst.size() > 0), 64'd1);
        if (exp_burst.size() > 0) begin
          want = exp_burst.pop_front();
          check("aw_addr", 64'(got.addr), 64'(want.addr));
          check("aw_len", 64'(got.len), 64'(want.len));
        end
        aw_log.push_back(got);
        beats_left = int'(bus.aw_len) + 1;
        aw_cnt++;
      end
      if (bus.w_valid && bus.w_ready) begin
        check("w_after_aw", 64'(beats_left > 0), 64'd1);
        check("w_data_expected", 64'(exp_data.size() > 0), 64'd1);
        if (exp_data.size() > 0) check("w_data", bus.w_data, exp_data.pop_front());
        check("w_last", 64'(bus.w_last), 64'(beats_left == 1));
        w_log.push_back(bus.w_data);
        beats_left--;
      end
      if (bus.b_valid && bus.b_ready) begin
        check("b_after_last_w", 64'(beats_left), 64'd0);
        resp_idx++;
      end
      if (done) begin
        check("done_bursts_drained", 64'(exp_burst.size()), 64'd0);
        check("done_data_drained", 64'(exp_data.size()), 64'd0);
        check("done_with_busy_low", 64'(busy), 64'd0);
        check("done_error", 64'(error), 64'(exp_error));
        done_cnt++;
      end
    end
  end

  initial begin
    int d0, k;
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset");
    check("if_read_ce", 64'(bus.if_read_ce), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Zero-length job: done one cycle after start, nothing else moves
    resp_plan.delete();
    plan_job(32'h2000, 0, 64'd0);
    kick(32'h2000, 0);
    #2;
    check("wc0_done", 64'(done), 64'd1);
    check("wc0_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2;
    check("wc0_done_one_cycle", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    #2;
    check("wc0_no_pop", 64'(pop_cnt), 64'd0);
    check("wc0_no_aw", 64'(aw_cnt), 64'd0);

    // 40 words at 0x1000, everything ready
    plan_job(32'h1000, 40, 64'd0);
    d0 = done_cnt;
    kick(32'h1000, 40);
    #2;
    check("start_busy", 64'(busy), 64'd1);
    check("start_if_read_low", 64'(bus.if_read), 64'd0);
    @(negedge clk);
    #2;
    check("start_if_read_high", 64'(bus.if_read), 64'd1);
    wait_done(400);
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("aw_count", 64'(aw_log.size()), 64'd3);
    check_aw(0, 32'h1000, 8'd15);
    check_aw(1, 32'h1080, 8'd15);
    check_aw(2, 32'h1100, 8'd7);
    check("beat_count", 64'(w_log.size()), 64'd40);
    if (w_log.size() == 40) begin
      check("w_first", w_log[0], 64'd0);
      check("w_last_word", w_log[39], 64'd39);
    end

    // Same job with a stuttering FIFO and random w_ready
    empty_toggle = 1;
    wr_rand      = 1;
    plan_job(32'h1000, 40, 64'd0);
    kick(32'h1000, 40);
    wait_done(2000);
    check("stall_beat_count", 64'(w_log.size()), 64'd40);
    check_aw(0, 32'h1000, 8'd15);
    check_aw(1, 32'h1080, 8'd15);
    check_aw(2, 32'h1100, 8'd7);
    if (w_log.size() == 40) check("stall_w20", w_log[20], 64'd20);
    empty_toggle = 0;
    wr_rand      = 0;

    // Page-crossing placement
    plan_job(32'h0FF0, 8, 64'd100);
    kick(32'h0FF0, 8);
    wait_done(200);
`ifdef KERNEL_BC_4K_SPLIT_EN
    check("split_aw_count", 64'(aw_log.size()), 64'd2);
    check_aw(0, 32'h0FF0, 8'd1);
    check_aw(1, 32'h1000, 8'd5);
`else
    check("split_aw_count", 64'(aw_log.size()), 64'd1);
    check_aw(0, 32'h0FF0, 8'd7);
`endif

    // SLVERR on the second of three bursts, then a clean job clears error
    resp_plan.delete();
    resp_plan.push_back(RESP_OKAY);
    resp_plan.push_back(RESP_SLVERR);
    resp_plan.push_back(RESP_OKAY);
    plan_job(32'h4000, 40, 64'd500);
    kick(32'h4000, 40);
    wait_done(400);
    @(negedge clk);
    #2;
    check("error_sticky", 64'(error), 64'd1);
    resp_plan.delete();
    plan_job(32'h5000, 4, 64'd900);
    kick(32'h5000, 4);
    #2;
    check("error_cleared_on_start", 64'(error), 64'd0);
    wait_done(200);

    // Reset in the middle of a data phase, then a fresh job
    plan_job(32'h6000, 16, 64'd300);
    kick(32'h6000, 16);
    k = 0;
    while (!bus.w_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reached_data_phase", 64'(bus.w_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    fifo_q.delete();
    exp_data.delete();
    exp_burst.delete();
    beats_left = 0;
    @(negedge clk);
    #2;
    check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    plan_job(32'h7000, 4, 64'd200);
    kick(32'h7000, 4);
    wait_done(200);
    check("post_reset_aw_count", 64'(aw_log.size()), 64'd1);
    check_aw(0, 32'h7000, 8'd3);
    if (w_log.size() == 4) check("post_reset_w3", w_log[3], 64'd203);
    else check("post_reset_beats", 64'(w_log.size()), 64'd4);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel_bc_fifo_burst_writer.md
# kernel_bc_fifo_burst_writer

Drain side of the kernel's 64-bit ap_fifo channels: pops a programmed number of words from an upstream first-word-fall-through FIFO (full_n/empty_n style), collects them into an internal burst buffer and writes them to memory as AXI4-style write bursts (AW/W/B). It sits between the BC compute pipeline's result FIFO and the memory write port. It runs one job per start pulse and reports completion and write errors.

## Interface
- DATA_WIDTH, 64, FIFO word and W beat width (multiple of 8)
- ADDR_WIDTH, 32, byte address width
- MAX_BURST, 16, max beats per burst (power of 2, 2..256)
- CNT_WIDTH, 32, width of word count
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  job start pulse, sampled only when idle
- base_addr  in  ADDR_WIDTH  job byte address, DATA_WIDTH/8-aligned
- word_count  in  CNT_WIDTH  words to transfer; 0 is legal
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky: any nonzero b_resp in the last job
- if_empty_n  in  1  upstream FIFO not empty; if_dout valid when high
- if_read  out  1  pop request (FIFO pops on if_read & if_empty_n)
- if_read_ce  out  1  tied 1
- if_dout  in  DATA_WIDTH  upstream FIFO head word
- aw_valid / aw_ready  out / in  1  address handshake
- aw_addr  out  ADDR_WIDTH  burst byte address
- aw_len  out  8  beats-1
- w_valid / w_ready  out / in  1  data handshake
- w_data  out  DATA_WIDTH  beat data
- w_last  out  1  final beat of burst
- b_valid / b_ready  in / out  1  response handshake
- b_resp  in  2  response code

## Operation
- FSM: IDLE, FILL, ADDR, DATA, RESP.
- IDLE: start=1 latches base_addr into cur_addr, word_count into remaining, clears error, busy<=1. If word_count==0 -> done pulse next cycle, stay IDLE. Else -> FILL.
- On FILL entry compute beats = min(MAX_BURST, remaining) (further clipped per Configuration); fill_idx<=0.
- FILL: if_read = (fill_idx < beats). On if_read & if_empty_n store if_dout into buf[fill_idx], fill_idx++. When fill_idx reaches beats -> ADDR. Empty FIFO stalls indefinitely; no timeout.
- ADDR: aw_valid=1, aw_addr=cur_addr, aw_len=beats-1, held stable until aw_ready. -> DATA, rd_idx<=0.
- DATA: w_valid=1, w_data=buf[rd_idx], w_last=(rd_idx==beats-1); advance on w_ready. After the last beat -> RESP.
- RESP: b_ready=1; on b_valid: error |= (b_resp!=0); cur_addr += beats*DATA_WIDTH/8; remaining -= beats. If remaining reaches 0 -> IDLE, done pulse, busy<=0; else -> FILL.
- One burst outstanding at a time; AW always precedes W.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow detection.
- start while busy is ignored.

## Timing
- Reset: state IDLE, busy=0, done=0, error=0, if_read=0, aw_valid=0, w_valid=0, b_ready=0, counters 0. Mid-job reset aborts immediately; words already popped are lost, partially issued bursts are not completed.
- start -> busy high next cycle; if_read high the cycle after.
- FILL pops at most one word per cycle; back-to-back pops when if_empty_n held high.
- Minimum per-burst overhead with ready always high: beats (fill) + 1 (AW) + beats (W) + 1 (B) cycles.
- done asserted exactly one cycle, coincident with busy falling.
- All outputs registered or decoded from registered state; no combinational path from aw_ready/w_ready/b_valid to any valid output.

## Configuration
- KERNEL_BC_4K_SPLIT_EN defined: beats is additionally clipped so a burst never crosses a 4 KB boundary (beats <= (4096 - cur_addr[11:0]) / (DATA_WIDTH/8)).
- Undefined: no boundary clipping; the caller guarantees legal placement.

## Structure
- Shared package kernel_bc_pkg: FSM state enum, AXI response codes (OKAY=0), BYTES_PER_BEAT constant, 4 KB constant.
- One sub-module: kernel_bc_burst_buf, MAX_BURST x DATA_WIDTH register array, synchronous write, asynchronous read by index.

## Test plan
- word_count=0, start -> done one cycle later, no if_read, no aw_valid.
- word_count=40, MAX_BURST=16, base 0x1000, ready/valid always high, FIFO full of 0..39 -> bursts aw_len 15,15,7 at 0x1000, 0x1080, 0x1100; w_data sequence 0..39; done once.
- FIFO empty_n toggled every other cycle, w_ready random 50% -> identical data and addresses, no dropped or duplicated beats.
- KERNEL_BC_4K_SPLIT_EN, base 0x0FF0, word_count=8 -> bursts aw_len 1 at 0x0FF0 and aw_len 5 at 0x1000; undefined -> single aw_len 7.
- b_resp=2 on second of three bursts -> job completes, error=1 after done; next start clears error.
- reset asserted in DATA mid-burst -> next cycle all outputs at reset values; fresh start with word_count=4 runs correctly.
